bin2seg_conv: RTL
=================

Name: bin2seg_conv

Overview:
- Upstream feeder for the 4-digit multiplexed 7-segment scanner.
- Takes a 14-bit binary value (0..9999) on a load strobe and converts it to BCD iteratively using shift-add-3 (double dabble).
- Maps each BCD digit to an 8-bit segment code and holds the four codes (k/h/d/u) stable for the scanner until the next conversion completes.

Parameters:
- BIN_W, 14, width of the binary input; fixed for 4 decimal digits.
- SEG_ACTIVE_LOW, 1, when 1 all segment codes are bit-inverted (common-anode panel).
- LZ_BLANK, 1, when 1 leading zeros are blanked; the units digit is never blanked.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- load  input  1  start-conversion strobe, one cycle, sampled only when idle
- bin_in  input  14  binary value to display
- dp_in  input  4  decimal-point enables, bit3=k .. bit0=u, active high, latched with load
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when new codes are valid
- ovf  output  1  high when the last accepted value was > 9999
- k_num  output  8  thousands segment code
- h_num  output  8  hundreds segment code
- d_num  output  8  tens segment code
- u_num  output  8  units segment code

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-low on rst_n.
  - Reset values: busy=0, done=0, ovf=0, k/h/d/u = blank code (0xFF when SEG_ACTIVE_LOW=1, else 0x00). State goes to IDLE.
- Segment code (active-high form, bit7=dp, bits6:0 = g..a):
  - Digits 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - blank = 00, dash = 40.
  - dp bit ORed in from the latched dp_in (also applies to blank and dash).
  - Inverted as a whole byte when SEG_ACTIVE_LOW=1.
- FSM states and transitions:
  - IDLE: if load=1, latch bin_in and dp_in, clear the 16-bit BCD accumulator, set the shift counter to 0, go to SHIFT. Otherwise stay. load=0 does nothing.
  - SHIFT: on each cycle, add 3 to every BCD nibble that is >= 5, then shift {bcd, bin} left by one. After BIN_W (14) SHIFT cycles go to UPDATE.
  - UPDATE: single cycle. Register the four segment codes, assert done=1 for this cycle, set ovf, go to IDLE.
- Timing:
  - busy=1 in SHIFT and UPDATE.
  - Latency: load seen in cycle N -> outputs and done valid at the clock edge ending cycle N+15. Codes are visible from cycle N+16.
  - A new load is accepted no earlier than the cycle after done.
- Overflow: if latched bin_in > 9999, ovf=1 and all four digits show dash (dp still applied). The BCD result is ignored.
- Leading-zero blanking (LZ_BLANK=1):
  - k is blanked if its digit = 0.
  - h is blanked if k and h are both 0.
  - d is blanked if k, h and d are all 0.
  - u always shows its digit.
- Boundary conditions:
  - load while busy: ignored, no queuing, outputs unaffected.
  - Outputs hold their last values indefinitely while in IDLE.
  - bin_in changing after the load cycle has no effect on the conversion.
  - rst_n low mid-conversion: at the next edge all outputs return to reset values and the FSM returns to IDLE. No done pulse.
  - Simultaneous load and rst_n=0: reset wins.

Decomposition:
- Shared package holds:
  - the segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH (active-high form);
  - the state encoding IDLE/SHIFT/UPDATE (2 bits);
  - MAX_DISP = 9999.
- One natural sub-module: seg_decode, a purely combinational BCD nibble + dp + blank/dash select -> 8-bit code with polarity parameter. It is instantiated four times.
- The double-dabble datapath and FSM stay in the top module.

Test Plan:
- Reset, then load bin_in=1234, dp_in=0000 -> busy for 15 cycles, done pulse, k=F9 h=A4 d=B0 u=99, ovf=0.
- Load 7, dp_in=0000, LZ_BLANK=1 -> k=h=d=FF, u=F8. Then load 0 -> k=h=d=FF, u=C0.
- Load 9999 with dp_in=0100 -> k=90 h=10 d=90 u=90, ovf=0. Then load 10000 -> all digits BF except h=3F, ovf=1.
- Load 1234, assert load=1 with 5678 at cycle 5 of SHIFT -> second load ignored, result 1234. Load 5678 after done -> k=92 h=82 d=F8 u=80.
- Assert rst_n=0 at cycle 8 of SHIFT -> next edge busy=0, all codes FF, no done pulse. Subsequent load 42 -> k=h=FF, d=99, u=A4.
- SEG_ACTIVE_LOW=0, LZ_BLANK=0, load 5 -> k=h=d=3F, u=6D.

Source files
------------

// File: rtl/bin2seg_conv_pkg.sv
// Shared constants and types for the binary-to-7-segment converter.
// Segment codes are stored in active-high form: bit7=dp, bits6:0 = g..a.
package bin2seg_conv_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;

    localparam logic [13:0] MAX_DISP = 14'd9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

endpackage

// File: rtl/bin2seg_conv_seg_decode.sv
// Combinational BCD nibble to 8-bit segment code with decimal point,
// blank/dash override and output polarity selection.
module seg_decode
    import bin2seg_conv_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] digit,
    input  logic       dp,
    input  logic       blank,
    input  logic       dash,
    output logic [7:0] code
);

    logic [7:0] raw_s;

    // Select the glyph, OR in the decimal point, then apply panel polarity.
    always_comb begin
        raw_s = SEG_BLANK;
        if (dash) begin
            raw_s = SEG_DASH;
        end else if (blank) begin
            raw_s = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    raw_s = SEG_0;
                4'd1:    raw_s = SEG_1;
                4'd2:    raw_s = SEG_2;
                4'd3:    raw_s = SEG_3;
                4'd4:    raw_s = SEG_4;
                4'd5:    raw_s = SEG_5;
                4'd6:    raw_s = SEG_6;
                4'd7:    raw_s = SEG_7;
                4'd8:    raw_s = SEG_8;
                4'd9:    raw_s = SEG_9;
                default: raw_s = SEG_DASH;
            endcase
        end
        raw_s = raw_s | {dp, 7'b000_0000};
        if (SEG_ACTIVE_LOW != 0) begin
            code = ~raw_s;
        end else begin
            code = raw_s;
        end
    end

endmodule

// File: rtl/bin2seg_conv.sv
// Iterative binary-to-BCD converter (shift-add-3) feeding four registered
// 7-segment codes for a multiplexed display scanner.
module bin2seg_conv
    import bin2seg_conv_pkg::*;
#(
    parameter int BIN_W          = 14,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int LZ_BLANK       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [BIN_W-1:0] bin_in,
    input  logic [3:0]       dp_in,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [7:0]       k_num,
    output logic [7:0]       h_num,
    output logic [7:0]       d_num,
    output logic [7:0]       u_num
);

    localparam logic [7:0] BLANK_CODE = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [3:0] LAST_SHIFT = 4'(BIN_W - 1);
    localparam bit         LZ_EN      = (LZ_BLANK != 0);

    state_t           state_r;
    logic [BIN_W-1:0] bin_r;
    logic [15:0]      bcd_r;
    logic [3:0]       cnt_r;
    logic [3:0]       dp_r;
    logic             ovf_pend_r;
    logic             busy_r;
    logic             done_r;
    logic             ovf_r;
    logic [7:0]       k_r, h_r, d_r, u_r;

    logic [15:0]      bcd_adj_s;
    logic             kz_s, hz_s, dz_s;
    logic             blank_k_s, blank_h_s, blank_d_s;
    logic [7:0]       k_code_s, h_code_s, d_code_s, u_code_s;

    // Add-3 correction on every nibble and leading-zero detection.
    always_comb begin
        bcd_adj_s = {add3(bcd_r[15:12]), add3(bcd_r[11:8]),
                     add3(bcd_r[7:4]),   add3(bcd_r[3:0])};
        kz_s      = (bcd_r[15:12] == 4'd0);
        hz_s      = (bcd_r[11:8]  == 4'd0);
        dz_s      = (bcd_r[7:4]   == 4'd0);
        blank_k_s = LZ_EN && kz_s;
        blank_h_s = LZ_EN && kz_s && hz_s;
        blank_d_s = LZ_EN && kz_s && hz_s && dz_s;
    end

    seg_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_k (
        .digit(bcd_r[15:12]), .dp(dp_r[3]), .blank(blank_k_s), .dash(ovf_pend_r), .code(k_code_s)
    );
    seg_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_h (
        .digit(bcd_r[11:8]),  .dp(dp_r[2]), .blank(blank_h_s), .dash(ovf_pend_r), .code(h_code_s)
    );
    seg_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_d (
        .digit(bcd_r[7:4]),   .dp(dp_r[1]), .blank(blank_d_s), .dash(ovf_pend_r), .code(d_code_s)
    );
    seg_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_u (
        .digit(bcd_r[3:0]),   .dp(dp_r[0]), .blank(1'b0),      .dash(ovf_pend_r), .code(u_code_s)
    );

    // Conversion FSM, double-dabble datapath and registered display codes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            bin_r      <= '0;
            bcd_r      <= 16'h0000;
            cnt_r      <= 4'd0;
            dp_r       <= 4'b0000;
            ovf_pend_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
            k_r        <= BLANK_CODE;
            h_r        <= BLANK_CODE;
            d_r        <= BLANK_CODE;
            u_r        <= BLANK_CODE;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (load) begin
                        bin_r      <= bin_in;
                        dp_r       <= dp_in;
                        ovf_pend_r <= (bin_in > MAX_DISP);
                        bcd_r      <= 16'h0000;
                        cnt_r      <= 4'd0;
                        busy_r     <= 1'b1;
                        state_r    <= SHIFT;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                SHIFT: begin
                    done_r         <= 1'b0;
                    {bcd_r, bin_r} <= {bcd_adj_s, bin_r} << 1;
                    cnt_r          <= cnt_r + 4'd1;
                    if (cnt_r == LAST_SHIFT) begin
                        state_r <= UPDATE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                UPDATE: begin
                    // Dash override for out-of-range values lives in the decoders.
                    k_r     <= k_code_s;
                    h_r     <= h_code_s;
                    d_r     <= d_code_s;
                    u_r     <= u_code_s;
                    ovf_r   <= ovf_pend_r;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign ovf   = ovf_r;
    assign k_num = k_r;
    assign h_num = h_r;
    assign d_num = d_r;
    assign u_num = u_r;

endmodule
